mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Read-side stream engine placed directly downstream of the dual-port `memory` block. It drives one read port of that block.
- It accepts a transfer command (base address and length) and issues sequential reads, wrapping modulo the memory depth.
- It returns the words on a valid/ready output stream with an end-of-transfer marker.
- It absorbs the memory's 1-cycle read latency and downstream backpressure, so no word is lost or duplicated.

Parameters:
- ADDR, 4, memory address width; depth = 2^ADDR.
- DATA, 8, memory word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_valid  in  1  command offer.
- start_ready  out  1  command accept; high only in IDLE.
- start_base  in  ADDR  first word address.
- start_len  in  ADDR+1  word count, 0..2^ADDR.
- mem_wr  out  1  memory write enable; constant 0.
- mem_addr  out  ADDR  memory read address (registered).
- mem_din  out  DATA  memory write data; constant 0.
- mem_dout  in  DATA  memory read data; valid the cycle after mem_addr is presented.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accept.
- out_data  out  DATA  stream word.
- out_last  out  1  high with the final word of a transfer.
- busy  out  1  high from command accept until the last word handshake completes.

Behaviour:
- Reset values: start_ready=1, mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0. State=IDLE, skid buffer empty, in-flight read flag cleared.
- Reset mid-transfer: return to IDLE on the next edge. Buffered and in-flight words are discarded, and the remaining count is cleared.
- Handshakes: a transfer fires when start_valid && start_ready at an edge. A word transfers when out_valid && out_ready at an edge.
- Output stability: while out_valid && !out_ready, out_data and out_last hold stable.
- States and transitions:
  - IDLE: on command accept, latch base and len. If len=0, stay in IDLE; produce no output and keep busy low. Otherwise go to RUN with busy=1.
  - RUN: issue one read per cycle while issued<len and (buffer occupancy + in-flight) < 2. mem_addr increments by 1 modulo 2^ADDR, so 2^ADDR-1 is followed by 0. When issued==len, go to DRAIN.
  - DRAIN: wait for outstanding words to be handshaken. On the handshake of the word with out_last=1, go to IDLE. start_ready rises the cycle after that handshake (1-cycle bubble between transfers).
- Latency: command handshake at edge E0; mem_addr=base during E0..E1; mem_dout captured into the skid buffer at E2; out_valid=1 after E2.
- Throughput: with out_ready held high, one word per cycle after the first.
- Skid buffer: 2 entries; the issue credit guarantees it never overflows. Simultaneous push and pop keeps occupancy unchanged.
- out_last is computed from the count of words delivered, not from the address, so it is correct across wrap-around and when len=2^ADDR.
- start_valid while busy: ignored. start_base and start_len are sampled only at the handshake edge.

Optional Feature:
- Macro: MEM_STREAM_READER_STATS_EN.
- When defined: adds output stall_count (16 bits).
  - Cleared to 0 on reset and at command accept.
  - Increments each cycle out_valid && !out_ready; saturates at 16'hFFFF.
  - Holds its value after the transfer ends.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_stream_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - SKID_DEPTH=2;
  - STALL_W=16;
  - the memory read-latency constant, equal to 1.
- One sub-module: stream_skid_fifo.
  - Parameterised by DATA.
  - 2-entry FIFO carrying {last, data}.
  - Provides push/pop, full/empty and occupancy outputs.

Test Plan:
1. Preload addresses 3..6 with 10,11,12,13; command base=3, len=4; out_ready=1 → out_valid first rises after E2; words 10,11,12,13 on 4 consecutive cycles; out_last only with 13; busy falls after the last handshake.
2. Same data with out_ready toggling 1,0,0,1,0,1... → exactly 10,11,12,13 in order, no duplicates; out_data stable during every stall; (occupancy + in-flight) ≤ 2 at all times; with STATS_EN, stall_count equals the number of stall cycles.
3. Wrap: preload 14,15,0,1 with 200,201,202,203; base=14, len=4 → mem_addr sequence 14,15,0,1; output 200..203; out_last on 203.
4. len=0 at base=5 → no out_valid; busy stays 0; start_ready=1 every cycle; a back-to-back command with base=5, len=1 returns mem[5].
5. Assert rst for one cycle after 2 of 6 words have been delivered → out_valid=0 and start_ready=1 after the reset edge; a following command base=0, len=2 delivers only mem[0], mem[1] (no stale words).
6. len=16, base=9, out_ready=1 → all 16 words delivered in address order 9..15,0..8; out_last on mem[8]; start_valid asserted during the transfer is not accepted.

Source files
------------

// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the memory stream reader.
// Optional stall statistics are enabled with MEM_STREAM_READER_STATS_EN.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned STALL_W    = 16;
    localparam int unsigned MEM_RD_LAT = 1;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// Command, memory read port and output stream bundle of the stream reader.
interface mem_stream_reader_if #(
    parameter int unsigned ADDR = 4,
    parameter int unsigned DATA = 8
);
    logic            start_valid;
    logic            start_ready;
    logic [ADDR-1:0] start_base;
    logic [ADDR:0]   start_len;

    logic            mem_wr;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_din;
    logic [DATA-1:0] mem_dout;

    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic            out_last;
    logic            busy;

    modport master (
        input  start_valid, start_base, start_len, mem_dout, out_ready,
        output start_ready, mem_wr, mem_addr, mem_din, out_valid, out_data, out_last, busy
    );

    modport slave (
        output start_valid, start_base, start_len, mem_dout, out_ready,
        input  start_ready, mem_wr, mem_addr, mem_din, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/mem_stream_reader_skid.sv
// Two-entry FIFO holding {last, data} words returned from memory.
module stream_skid_fifo
    import mem_stream_pkg::*;
#(
    parameter int unsigned DATA = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DATA:0] push_data,
    input  logic          pop,
    output logic [DATA:0] head,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);
    logic [DATA:0] slot_q [SKID_DEPTH];
    logic [DATA:0] slot_d [SKID_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = slot_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'(SKID_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mem_stream_reader.sv
// Sequential memory read engine: command in, valid/ready word stream out.
// Define MEM_STREAM_READER_STATS_EN to add the stall_count output.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int unsigned ADDR = 4,
    parameter int unsigned DATA = 8
) (
    input logic clk,
    input logic rst,
    mem_stream_reader_if.master bus
`ifdef MEM_STREAM_READER_STATS_EN
    ,
    output logic [STALL_W-1:0] stall_count
`endif
);
    state_e                state_q, state_d;
    logic [ADDR-1:0]       addr_q, addr_d;
    logic [ADDR:0]         len_q, len_d;
    logic [ADDR:0]         issued_q, issued_d;
    logic [ADDR:0]         pushed_q, pushed_d;
    logic [MEM_RD_LAT-1:0] inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  start_ready_q, start_ready_d;
`ifdef MEM_STREAM_READER_STATS_EN
    logic [STALL_W-1:0]    stall_count_q, stall_count_d;
`endif

    logic          accept;
    logic          issue;
    logic          fifo_push;
    logic          fifo_pop;
    logic [DATA:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_count;
    logic [2:0]    credit_used;
    logic          out_valid;

    assign out_valid = ~fifo_empty;
    assign accept    = bus.start_valid & start_ready_q;
    assign fifo_pop  = out_valid & bus.out_ready;
    assign fifo_push = inflight_q[0] & ~fifo_full;

    // A word popped this edge frees its slot in time for a read issued now,
    // which is what sustains one word per cycle with only two skid entries.
    assign credit_used = 3'(fifo_count) + 3'(inflight_q[0]) - 3'(fifo_pop);
    assign issue = (state_q == RUN) && (issued_q != len_q) &&
                   (credit_used < 3'(SKID_DEPTH));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        pushed_d   = pushed_q;
        busy_d     = busy_q;
        inflight_d = '0;
        inflight_d[0] = issue;

        if (fifo_push) begin
            pushed_d = pushed_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = bus.start_base;
                    len_d    = bus.start_len;
                    issued_d = '0;
                    pushed_d = '0;
                    if (bus.start_len != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_q + 1'b1 == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_head[DATA]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
    end

`ifdef MEM_STREAM_READER_STATS_EN
    always_comb begin
        stall_count_d = stall_count_q;
        if (accept) begin
            stall_count_d = '0;
        end else if (out_valid && !bus.out_ready) begin
            stall_count_d = sat_inc(stall_count_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            pushed_q      <= '0;
            inflight_q    <= '0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
`ifdef MEM_STREAM_READER_STATS_EN
            stall_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            pushed_q      <= pushed_d;
            inflight_q    <= inflight_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
`ifdef MEM_STREAM_READER_STATS_EN
            stall_count_q <= stall_count_d;
`endif
        end
    end

    // Last flag is tagged by word count at capture, so address wrap is irrelevant.
    stream_skid_fifo #(
        .DATA(DATA)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data({pushed_q + 1'b1 == len_q, bus.mem_dout}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.start_ready = start_ready_q;
    assign bus.mem_wr      = 1'b0;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_din     = '0;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = fifo_head[DATA-1:0];
    assign bus.out_last    = out_valid & fifo_head[DATA];
    assign bus.busy        = busy_q;
`ifdef MEM_STREAM_READER_STATS_EN
    assign stall_count     = stall_count_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: queue-based transfer model plus directed tests.
module tb_mem_stream_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stream_reader_if #(.ADDR(4), .DATA(8)) bus ();
`ifdef MEM_STREAM_READER_STATS_EN
    logic [15:0] stall_count;
`endif

    mem_stream_reader #(.ADDR(4), .DATA(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_STREAM_READER_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    // Synchronous-read memory the reader is attached to.
    logic [7:0] mem [16];
    always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event-missing required=event @%0t", name, $time);
    endtask

    // Model: expected words of the running transfer, in delivery order.
    logic [8:0]  exp_q [$];
    logic        busy_m = 1'b0;
    logic        hold_m = 1'b0;
    logic [8:0]  held_m;
    logic [15:0] stall_m = '0;
    int          hs_count = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          last_hs_cyc = 0;
    logic [7:0]  last_data_seen = '0;
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic was_busy;
        cyc++;
        if (rst) begin
            exp_q.delete();
            busy_m = 1'b0;
            hold_m = 1'b0;
            stall_m = '0;
        end else begin
            was_busy = busy_m;
            hold_m = bus.out_valid && !bus.out_ready;
            held_m = {bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                if (exp_q[0][8]) begin
                    busy_m = 1'b0;
                    last_data_seen = exp_q[0][7:0];
                    last_hs_cyc = cyc;
                end
                void'(exp_q.pop_front());
                hs_count++;
            end
            if (bus.out_valid && !bus.out_ready && stall_m != 16'hFFFF) stall_m++;
            if (bus.start_valid && !was_busy) begin
                stall_m = '0;
                accept_cyc = cyc;
                for (int i = 0; i < int'(bus.start_len); i++)
                    exp_q.push_back({i == int'(bus.start_len) - 1,
                                     mem[(int'(bus.start_base) + i) % 16]});
                if (bus.start_len != 0) busy_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && started) begin
            check("start_ready", bus.start_ready, !busy_m);
            check("busy", bus.busy, busy_m);
            check("mem_wr", bus.mem_wr, 0);
            if (hold_m) begin
                check("stall_valid_held", bus.out_valid, 1);
                check("stall_word_held", {bus.out_last, bus.out_data}, held_m);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_word");
                else check("out_word", {bus.out_last, bus.out_data}, exp_q[0]);
            end
`ifdef MEM_STREAM_READER_STATS_EN
            check("stall_count", stall_count, stall_m);
`endif
        end
    end

    task automatic issue_cmd(input logic [3:0] b, input logic [4:0] l);
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.start_base  = b;
        bus.start_len   = l;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            @(posedge clk); #1;
            if (!busy_m && exp_q.size() == 0) break;
        end
        if (n == bound) fail_now("wait_idle_timeout");
    endtask

    logic       v [7];
    logic [7:0] d [7];
    logic       l [7];
    logic       b [7];
    logic [3:0] a [4];
    int         hs0;
    int         n;
    logic [7:0] ready_pat;

    initial begin
        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.start_base  = '0;
        bus.start_len   = '0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        started = 1'b1;

        // 1: basic transfer, latency and throughput
        mem[3] = 10; mem[4] = 11; mem[5] = 12; mem[6] = 13;
        bus.out_ready = 1'b1;
        issue_cmd(3, 4);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            v[k] = bus.out_valid; d[k] = bus.out_data; l[k] = bus.out_last; b[k] = bus.busy;
        end
        check("t1_valid_e0", v[0], 0);
        check("t1_valid_e1", v[1], 0);
        check("t1_busy_e0", b[0], 1);
        for (int k = 2; k < 6; k++) begin
            check("t1_valid_run", v[k], 1);
            check("t1_data", d[k], 8'(8 + k));
            check("t1_last", l[k], k == 5);
        end
        check("t1_valid_after", v[6], 0);
        check("t1_busy_after", b[6], 0);
        wait_idle(20);

        // 2: backpressure pattern 1,0,0,1,0,1,1,0
        ready_pat = 8'b0110_1001;
        hs0 = hs_count;
        issue_cmd(3, 4);
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            bus.out_ready = ready_pat[n % 8];
            if (!busy_m && exp_q.size() == 0) break;
        end
        if (n == 100) fail_now("t2_timeout");
        bus.out_ready = 1'b1;
        check("t2_words", hs_count - hs0, 4);
        check("t2_last_word", last_data_seen, 13);

        // 3: address wrap-around
        mem[14] = 200; mem[15] = 201; mem[0] = 202; mem[1] = 203;
        hs0 = hs_count;
        issue_cmd(14, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a[k] = bus.mem_addr;
        end
        check("t3_addr0", a[0], 14);
        check("t3_addr1", a[1], 15);
        check("t3_addr2", a[2], 0);
        check("t3_addr3", a[3], 1);
        wait_idle(20);
        check("t3_words", hs_count - hs0, 4);
        check("t3_last_word", last_data_seen, 203);

        // 4: zero-length command then back-to-back single word
        mem[5] = 77;
        hs0 = hs_count;
        @(posedge clk); #1;
        bus.start_valid = 1'b1; bus.start_base = 5; bus.start_len = 0;
        @(posedge clk); #1;
        bus.start_len = 1;
        @(negedge clk);
        check("t4_busy_len0", bus.busy, 0);
        check("t4_ready_len0", bus.start_ready, 1);
        check("t4_valid_len0", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        wait_idle(20);
        check("t4_words", hs_count - hs0, 1);
        check("t4_last_word", last_data_seen, 77);

        // 5: reset in the middle of a transfer
        for (int i = 10; i < 16; i++) mem[i] = 8'(20 + i);
        mem[0] = 90; mem[1] = 91;
        hs0 = hs_count;
        issue_cmd(10, 6);
        for (n = 0; n < 50; n++) begin
            if (hs_count - hs0 >= 2) break;
            @(posedge clk); #1;
        end
        if (n == 50) fail_now("t5_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after_rst", bus.out_valid, 0);
        check("t5_ready_after_rst", bus.start_ready, 1);
        hs0 = hs_count;
        issue_cmd(0, 2);
        wait_idle(20);
        check("t5_words", hs_count - hs0, 2);
        check("t5_last_word", last_data_seen, 91);

        // 6: full-depth transfer with a command offered while busy
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
        hs0 = hs_count;
        issue_cmd(9, 16);
        repeat (2) @(posedge clk);
        #1;
        bus.start_valid = 1'b1; bus.start_base = 0; bus.start_len = 3;
        @(negedge clk);
        check("t6_ready_busy", bus.start_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        wait_idle(60);
        check("t6_words", hs_count - hs0, 16);
        check("t6_last_word", last_data_seen, 8'h48);
        check("t6_duration", last_hs_cyc - accept_cyc, 18);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
